// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, flush, forwarding and memory-wait control for a 5-stage RV32I pipeline.
// Optional single-step debug mode is enabled by defining PIPE_SINGLE_STEP_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic             resultSrcE0,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             memReqM,
  input  logic             memReadyM,
`ifdef PIPE_SINGLE_STEP_EN
  input  logic             stepMode,
  input  logic             stepReq,
`endif
  output logic             enF,
  output logic             enD,
  output logic             enE,
  output logic             enM,
  output logic             enW,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCount
);
`ifdef PIPE_SINGLE_STEP_EN
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR, HALT} state_t;
  logic step_q;
  logic step_edge;
`else
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
`endif
  state_t state;
  logic [7:0] wait_cnt;
  logic lw_stall;
  logic mem_hold;
  logic idle;
  always_comb begin
    forwardAE = (regWriteM && rdM != 5'd0 && rdM == rs1E) ? 2'b10 :
                (regWriteW && rdW != 5'd0 && rdW == rs1E) ? 2'b01 : 2'b00;
    forwardBE = (regWriteM && rdM != 5'd0 && rdM == rs2E) ? 2'b10 :
                (regWriteW && rdW != 5'd0 && rdW == rs2E) ? 2'b01 : 2'b00;
    lw_stall = resultSrcE0 && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);
    mem_hold = (state == MEM_WAIT) ? !memReadyM : (memReqM && !memReadyM);
`ifdef PIPE_SINGLE_STEP_EN
    step_edge = stepReq && !step_q;
    idle = state == ERROR || (state == HALT && !step_edge);
`else
    idle = state == ERROR;
`endif
    // A memory freeze holds E in place, so only W is bubbled
    enF = !idle && !mem_hold && !lw_stall;
    enD = !idle && !mem_hold && !lw_stall;
    enE = !idle && !mem_hold;
    enM = !idle && !mem_hold;
    enW = !idle;
    flushE = !idle && !mem_hold && lw_stall;
    flushW = idle || mem_hold;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wait_cnt <= 8'd0;
      memErr <= 1'b0;
      stallCount <= '0;
`ifdef PIPE_SINGLE_STEP_EN
      step_q <= 1'b0;
`endif
    end else begin
      if (!enF) stallCount <= stallCount + CNT_W'(1);
`ifdef PIPE_SINGLE_STEP_EN
      step_q <= stepReq;
`endif
      case (state)
        RUN: begin
          if (mem_hold) begin
            state <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
`ifdef PIPE_SINGLE_STEP_EN
          else if (stepMode) state <= HALT;
`endif
        end
        MEM_WAIT: begin
          if (memReadyM) begin
`ifdef PIPE_SINGLE_STEP_EN
            state <= stepMode ? HALT : RUN;
`else
            state <= RUN;
`endif
            wait_cnt <= 8'd0;
          end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
            state <= ERROR;
            memErr <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
`ifdef PIPE_SINGLE_STEP_EN
        HALT: begin
          if (step_edge && mem_hold) begin
            state <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end else if (!stepMode) begin
            state <= RUN;
          end
        end
`endif
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic resultSrcE0, regWriteM, regWriteW, memReqM, memReadyM;
`ifdef PIPE_SINGLE_STEP_EN
  logic stepMode, stepReq;
`endif
  logic enF, enD, enE, enM, enW, flushE, flushW, memErr;
  logic [1:0] forwardAE, forwardBE;
  logic [31:0] stallCount;
  logic t_enF, t_enD, t_enE, t_enM, t_enW, t_flushE, t_flushW, t_memErr;
  logic [1:0] t_forwardAE, t_forwardBE;
  logic [31:0] t_stallCount;
  int checks = 0;
  int errors = 0;
  bit m_err, m_waiting;
  int m_wc;
  logic [31:0] m_stall;
  logic [4:0] e_en;
  logic e_fe, e_fw;
  logic [1:0] e_fa, e_fb;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .resultSrcE0(resultSrcE0), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM),
    .regWriteW(regWriteW), .memReqM(memReqM), .memReadyM(memReadyM),
`ifdef PIPE_SINGLE_STEP_EN
    .stepMode(stepMode), .stepReq(stepReq),
`endif
    .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enW(enW), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .memErr(memErr), .stallCount(stallCount));

  pipe_hazard_ctrl #(.MEM_TIMEOUT(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .resultSrcE0(resultSrcE0), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM),
    .regWriteW(regWriteW), .memReqM(memReqM), .memReadyM(memReadyM),
`ifdef PIPE_SINGLE_STEP_EN
    .stepMode(stepMode), .stepReq(stepReq),
`endif
    .enF(t_enF), .enD(t_enD), .enE(t_enE), .enM(t_enM), .enW(t_enW), .flushE(t_flushE),
    .flushW(t_flushW), .forwardAE(t_forwardAE), .forwardBE(t_forwardBE), .memErr(t_memErr),
    .stallCount(t_stallCount));

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (regWriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regWriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle_inputs();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {resultSrcE0, regWriteM, regWriteW, memReqM, memReadyM} = '0;
`ifdef PIPE_SINGLE_STEP_EN
    stepMode = 1'b0;
    stepReq = 1'b0;
`endif
  endtask

  task automatic model_reset();
    m_err = 0;
    m_waiting = 0;
    m_wc = 0;
    m_stall = 0;
  endtask

  task automatic model_eval();
    bit lw, hold;
    lw = resultSrcE0 && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    hold = m_waiting ? !memReadyM : (memReqM && !memReadyM);
    e_fa = fwd(rs1E);
    e_fb = fwd(rs2E);
    if (m_err) begin e_en = 5'b00000; e_fe = 0; e_fw = 1; end
    else if (hold) begin e_en = 5'b00001; e_fe = 0; e_fw = 1; end
    else if (lw) begin e_en = 5'b00111; e_fe = 1; e_fw = 0; end
    else begin e_en = 5'b11111; e_fe = 0; e_fw = 0; end
  endtask

  task automatic model_step();
    if (!e_en[4]) m_stall = m_stall + 1;
    if (m_err) return;
    if (m_waiting) begin
      if (memReadyM) begin m_waiting = 0; m_wc = 0; end
      else if (m_wc == TO) m_err = 1;
      else m_wc++;
    end else if (memReqM && !memReadyM) begin
      m_waiting = 1;
      m_wc = 1;
    end
  endtask

  task automatic settle();
    #1 model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    settle();
    checks++;
    if ({enF, enD, enE, enM, enW} !== 5'b11111) begin errors++; $display("FAIL reset_en got %b want 11111", {enF, enD, enE, enM, enW}); end
    checks++;
    if ({flushE, flushW, forwardAE, forwardBE} !== 6'b0) begin errors++; $display("FAIL reset_flush_fwd got %b want 000000", {flushE, flushW, forwardAE, forwardBE}); end
    checks++;
    if (stallCount !== 32'd0 || memErr !== 1'b0) begin errors++; $display("FAIL reset_cnt_err got cnt=%0d err=%b want 0 0", stallCount, memErr); end
  endtask

  task automatic test_load_use();
    logic [31:0] s0;
    s0 = m_stall;
    resultSrcE0 = 1; rdE = 5; rs1D = 5;
    settle();
    checks++;
    if ({enF, enD, enE, enM, enW, flushE} !== 6'b001111) begin errors++; $display("FAIL lw_stall got en=%b fe=%b want 00111 1", {enF, enD, enE, enM, enW}, flushE); end
    tick();
    resultSrcE0 = 0; rdE = 0;
    settle();
    checks++;
    if ({enF, enD, flushE} !== 3'b110 || stallCount !== s0 + 1) begin errors++; $display("FAIL lw_one_cycle got enF=%b fe=%b cnt=%0d want 1 0 %0d", enF, flushE, stallCount, s0 + 1); end
    tick();
    resultSrcE0 = 1; rdE = 0; rs1D = 0;
    settle();
    checks++;
    if ({enF, enD, flushE} !== 3'b110) begin errors++; $display("FAIL lw_x0 got enF=%b enD=%b fe=%b want 1 1 0", enF, enD, flushE); end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] s0;
    s0 = m_stall;
    resultSrcE0 = 1; rdE = 5; rs1D = 5;
    settle();
    checks++;
    if ({enF, flushE} !== 2'b01) begin errors++; $display("FAIL b2b_first got enF=%b fe=%b want 0 1", enF, flushE); end
    tick();
    rdE = 6; rs1D = 1; rs2D = 6;
    settle();
    checks++;
    if ({enF, flushE} !== 2'b01) begin errors++; $display("FAIL b2b_second got enF=%b fe=%b want 0 1", enF, flushE); end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (stallCount !== s0 + 2) begin errors++; $display("FAIL b2b_count got %0d want %0d", stallCount, s0 + 2); end
  endtask

  task automatic test_forward();
    rs1E = 3; rdM = 3; regWriteM = 1; rdW = 3; regWriteW = 1;
    settle();
    checks++;
    if (forwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_prio got %b want 10", forwardAE); end
    tick();
    regWriteM = 0; rs2E = 3;
    settle();
    checks++;
    if (forwardAE !== 2'b01 || forwardBE !== 2'b01) begin errors++; $display("FAIL fwd_w got A=%b B=%b want 01 01", forwardAE, forwardBE); end
    tick();
    rs1E = 0; rs2E = 0; rdW = 0; rdM = 0; regWriteM = 1;
    settle();
    checks++;
    if (forwardAE !== 2'b00 || forwardBE !== 2'b00) begin errors++; $display("FAIL fwd_x0 got A=%b B=%b want 00 00", forwardAE, forwardBE); end
    tick();
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    logic [31:0] s0;
    s0 = m_stall;
    memReqM = 1; memReadyM = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if ({enF, enD, enE, enM, enW, flushE, flushW} !== 7'b0000101) begin errors++; $display("FAIL mem_freeze[%0d] got en=%b fe=%b fw=%b want 00001 0 1", i, {enF, enD, enE, enM, enW}, flushE, flushW); end
      tick();
    end
    memReadyM = 1;
    settle();
    checks++;
    if ({enF, enD, enE, enM, enW, flushW} !== 6'b111110) begin errors++; $display("FAIL mem_release got en=%b fw=%b want 11111 0", {enF, enD, enE, enM, enW}, flushW); end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (stallCount !== s0 + 4 || memErr !== 1'b0) begin errors++; $display("FAIL mem_count got cnt=%0d err=%b want %0d 0", stallCount, memErr, s0 + 4); end
  endtask

  task automatic test_timeout();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    memReqM = 1; memReadyM = 0;
    n = 0;
    for (int i = 0; i < 20 && !t_memErr; i++) begin
      tick();
      n++;
    end
    checks++;
    if (t_memErr !== 1'b1 || n != 4) begin errors++; $display("FAIL timeout_entry got err=%b cycles=%0d want 1 4", t_memErr, n); end
    memReqM = 0; memReadyM = 1;
    for (int i = 0; i < 3; i++) tick();
    #1;
    checks++;
    if ({t_enF, t_enD, t_enE, t_enM, t_enW, t_flushW, t_memErr} !== 7'b0000011) begin errors++; $display("FAIL timeout_sticky got en=%b fw=%b err=%b want 00000 1 1", {t_enF, t_enD, t_enE, t_enM, t_enW}, t_flushW, t_memErr); end
    checks++;
    if (t_stallCount !== 32'd7) begin errors++; $display("FAIL timeout_count got %0d want 7", t_stallCount); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    idle_inputs();
    settle();
    checks++;
    if ({t_enF, t_enD, t_enE, t_enM, t_enW, t_memErr, t_stallCount} !== {6'b111110, 32'd0}) begin errors++; $display("FAIL timeout_reset got en=%b err=%b cnt=%0d want 11111 0 0", {t_enF, t_enD, t_enE, t_enM, t_enW}, t_memErr, t_stallCount); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE = 5'($urandom_range(0, 3)); rdM = 5'($urandom_range(0, 3)); rdW = 5'($urandom_range(0, 3));
      resultSrcE0 = $urandom_range(0, 1) == 1;
      regWriteM = $urandom_range(0, 1) == 1;
      regWriteW = $urandom_range(0, 1) == 1;
      memReqM = $urandom_range(0, 9) < 3;
      memReadyM = $urandom_range(0, 9) < 6;
      settle();
      checks++;
      if ({enF, enD, enE, enM, enW} !== e_en || flushE !== e_fe || flushW !== e_fw) begin errors++; $display("FAIL rand_ctrl[%0d] got en=%b fe=%b fw=%b want %b %b %b", i, {enF, enD, enE, enM, enW}, flushE, flushW, e_en, e_fe, e_fw); end
      checks++;
      if (forwardAE !== e_fa || forwardBE !== e_fb) begin errors++; $display("FAIL rand_fwd[%0d] got %b %b want %b %b", i, forwardAE, forwardBE, e_fa, e_fb); end
      checks++;
      if (stallCount !== m_stall || memErr !== m_err) begin errors++; $display("FAIL rand_state[%0d] got cnt=%0d err=%b want %0d %b", i, stallCount, memErr, m_stall, m_err); end
      tick();
    end
    idle_inputs();
  endtask

`ifdef PIPE_SINGLE_STEP_EN
  task automatic test_single_step();
    int runs;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    stepMode = 1;
    tick();
    runs = 0;
    for (int i = 0; i < 24; i++) begin
      stepReq = (i % 8 == 2) || (i % 8 == 3);
      #1;
      if (enF) runs++;
      tick();
    end
    checks++;
    if (runs != 3) begin errors++; $display("FAIL single_step got %0d run cycles want 3", runs); end
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_back_to_back();
    test_forward();
    test_mem_wait();
    test_random();
    test_timeout();
`ifdef PIPE_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
